// File: rtl/dcache_direct_wb.sv
// dcache_direct_wb: direct-mapped, write-back, write-allocate data cache for the
// CPU-side D-cache port. Hits cost no extra cycles. A miss stalls the core while
// the FSM writes back a dirty victim (WB) and refills the 4-word line (ALLOC)
// over a 128-bit memory port.
// Optional build macro: DCACHE_PERF_CNT_EN adds the hit_cnt/miss_cnt outputs.
module dcache_direct_wb #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_ren,
  input  logic              proc_wen,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic              proc_stall,
  output logic [31:0]       proc_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic              mem_ready,
  input  logic [127:0]      mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int LINES = 2**IDX_W;
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

  state_t            state_reg;
  logic [LINES-1:0]  valid_reg;
  logic [LINES-1:0]  dirty_reg;
  logic [TAG_W-1:0]  tag_reg  [LINES];
  logic [127:0]      data_reg [LINES];

  logic              mem_read_reg;
  logic              mem_write_reg;
  logic [ADDR_W-3:0] mem_addr_reg;
  logic [127:0]      mem_wdata_reg;

  // Address fields of the current CPU request.
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [1:0]        req_word;
  assign req_tag  = proc_addr[ADDR_W-1:2+IDX_W];
  assign req_idx  = proc_addr[1+IDX_W:2];
  assign req_word = proc_addr[1:0];

  logic req;
  logic hit;
  logic is_idle;
  logic write_hit;
  logic refill_done;
  assign req         = proc_ren | proc_wen;
  assign hit         = valid_reg[req_idx] && (tag_reg[req_idx] == req_tag);
  assign is_idle     = (state_reg == IDLE);
  // A write wins over a simultaneous read; the read data is simply unused.
  assign write_hit   = is_idle && proc_wen && hit;
  assign refill_done = (state_reg == ALLOC) && mem_ready;

  // Stall is combinational in IDLE so a miss freezes the core in its own cycle.
  assign proc_stall = !is_idle || (req && !hit);

  // Split the indexed line into words and select the requested one.
  logic [31:0] line_words [4];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign line_words[gi] = data_reg[req_idx][gi*32 +: 32];
    end
  endgenerate
  assign proc_rdata = line_words[req_word];

  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // Miss-handling FSM with registered memory-side outputs and line state bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      dirty_reg     <= '0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (write_hit) dirty_reg[req_idx] <= 1'b1;
          if (req && !hit) begin
            if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
              // Victim line must go back to memory before it is overwritten.
              state_reg     <= WB;
              mem_write_reg <= 1'b1;
              mem_addr_reg  <= {tag_reg[req_idx], req_idx};
              mem_wdata_reg <= data_reg[req_idx];
            end else begin
              state_reg    <= ALLOC;
              mem_read_reg <= 1'b1;
              mem_addr_reg <= proc_addr[ADDR_W-1:2];
            end
          end
        end
        WB: begin
          if (mem_ready) begin
            state_reg     <= ALLOC;
            mem_write_reg <= 1'b0;
            mem_read_reg  <= 1'b1;
            mem_addr_reg  <= proc_addr[ADDR_W-1:2];
          end
        end
        ALLOC: begin
          if (mem_ready) begin
            state_reg          <= IDLE;
            mem_read_reg       <= 1'b0;
            valid_reg[req_idx] <= 1'b1;
            dirty_reg[req_idx] <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Data and tag arrays: refill replaces a whole line, write hits merge one word.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (refill_done) begin
        data_reg[req_idx] <= mem_rdata;
        tag_reg[req_idx]  <= req_tag;
      end else if (write_hit) begin
        data_reg[req_idx][{req_word, 5'd0} +: 32] <= proc_wdata;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic        refilled_reg;
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;

  // The first IDLE cycle after a refill services the missed request; it is not a new hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refilled_reg <= 1'b0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      refilled_reg <= refill_done;
      if (is_idle && req && hit && !refilled_reg) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      if (is_idle && req && !hit) miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`endif

endmodule
